// File: rtl/prog_loader_pkg.sv
// Shared loader definitions: FSM state encoding, frame constants, default sizes.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_e;

    // Frame layout: little-endian 16-bit word count, payload, one XOR byte.
    localparam int LEN_BYTES         = 2;
    localparam int CHK_BYTES         = 1;
    localparam int DEFAULT_MAX_WORDS = 16384;

endpackage

// File: rtl/prog_loader_timeout.sv
// Idle-cycle counter with clear, enable and an early terminal-count flag.
module loader_timeout #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt_q;

    // Count idle cycles; any clear wins over enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)      cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i)  cnt_q <= cnt_q + 1'b1;
    end

    // Flag one cycle early so the owner changes state on the same edge the
    // count reaches TIMEOUT_CYC-1.
    assign tc_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT_CYC - 2));

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses a length/payload/checksum frame and
// writes 32-bit words into program RAM while holding the CPU in reset.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int MAX_WORDS   = DEFAULT_MAX_WORDS,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_e              state_q, state_d;
    logic [15:0]         count_q, count_d;
    logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         shreg_q, shreg_d;
    logic [7:0]          chk_q, chk_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                loading, accept, tmo_tc;
    logic [15:0]         new_count;

    assign loading    = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                        (state_q == S_DATA) || (state_q == S_CHK);
    assign accept     = byte_valid && loading;
    assign new_count  = {byte_data, count_q[7:0]};

    assign byte_ready = loading;
    assign busy       = loading;
    assign cpu_hold   = loading || (state_q == S_ERR);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

    // Counter is held clear outside a download so each frame starts fresh.
    loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .clock (clock),
        .reset (reset),
        .clr_i (accept || !loading),
        .en_i  (loading && !accept),
        .tc_o  (tmo_tc)
    );

    // State and datapath registers; reset aborts any write in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
            chk_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            chk_q      <= chk_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Frame parser: next state, word assembly, checksum and write strobe.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        chk_d      = chk_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN0;
                    count_d    = '0;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    shreg_d    = '0;
                    chk_d      = '0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    count_d[7:0] = byte_data;
                    state_d      = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    count_d = new_count;
                    if (32'(new_count) > 32'(MAX_WORDS)) state_d = S_ERR;
                    else if (new_count == 16'd0)         state_d = S_CHK;
                    else                                  state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    shreg_d    = {byte_data, shreg_q[31:8]};
                    chk_d      = chk_q ^ byte_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = word_idx_q;
                        wdata_d    = {byte_data, shreg_q[31:8]};
                        word_idx_d = word_idx_q + 1'b1;
                        if (word_idx_q == ADDR_W'(count_q - 16'd1))
                            state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (accept) state_d = (byte_data == chk_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase

        if (tmo_tc) state_d = S_ERR;
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued as frames
// are sent and retired by a write monitor.
module tb_prog_loader;

    localparam int ADDR_W = 14;
    localparam int TMO    = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready, mem_we, cpu_hold, busy, done, error;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    int checks = 0;
    int errors = 0;
    int wcnt   = 0;
    logic [45:0] exp_q[$];

    prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(16384), .TIMEOUT_CYC(TMO)) dut (
        .clock(clock), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            wcnt++;
            if (exp_q.size() == 0) chk("unexpected_we", {18'd0, mem_addr, mem_wdata}, 64'h0);
            else begin
                logic [45:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e[45:32]));
                chk("wr_data", 64'(mem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic st);
        @(negedge clock);
        chk("ready", 64'(byte_ready), 64'd1);
        byte_valid = 1'b1;
        byte_data  = b;
        start      = st;
        @(posedge clock);
        #1;
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int idx, inout logic [7:0] x);
        exp_q.push_back({ADDR_W'(idx), w});
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], 1'b0);
            x = x ^ w[8*i +: 8];
        end
    endtask

    // {byte_ready, mem_we, cpu_hold, busy, done, error}
    function automatic logic [5:0] flags();
        return {byte_ready, mem_we, cpu_hold, busy, done, error};
    endfunction

    initial begin
        logic [7:0] x;
        int n;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_flags", 64'(flags()), 64'h0);
        chk("reset_addr", 64'(mem_addr), 64'h0);
        reset = 1'b0;

        // Normal 2-word load
        pulse_start();
        @(negedge clock);
        chk("start_flags", 64'(flags()), 64'(6'b101100));
        wcnt = 0; x = 8'h00;
        send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
        send_word(32'h12345678, 0, x);
        send_word(32'hDEADBEEF, 1, x);
        send_byte(x, 1'b0);
        @(negedge clock);
        chk("norm_flags", 64'(flags()), 64'(6'b000010));
        chk("norm_wcnt", 64'(wcnt), 64'd2);
        chk("norm_addr_hold", 64'(mem_addr), 64'd1);

        // Zero length
        pulse_start();
        wcnt = 0;
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        @(negedge clock);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_wcnt", 64'(wcnt), 64'd0);

        // Bad checksum
        pulse_start();
        wcnt = 0; x = 8'h00;
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_word(32'h04030201, 0, x);
        chk("bad_xor_model", 64'(x), 64'h04);
        send_byte(8'hFF, 1'b0);
        @(negedge clock);
        chk("bad_flags", 64'(flags()), 64'(6'b001001));
        chk("bad_wcnt", 64'(wcnt), 64'd1);

        // Oversize count
        pulse_start();
        wcnt = 0;
        send_byte(8'h01, 1'b0); send_byte(8'h41, 1'b0);
        @(negedge clock);
        chk("over_flags", 64'(flags()), 64'(6'b001001));
        repeat (4) @(negedge clock);
        chk("over_wcnt", 64'(wcnt), 64'd0);

        // Timeout after two payload bytes
        pulse_start();
        wcnt = 0;
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
        n = 0;
        while (n < 40) begin
            @(negedge clock);
            n++;
            if (error === 1'b1) break;
        end
        chk("tmo_cycles", 64'(n), 64'd16);
        chk("tmo_hold", 64'(cpu_hold), 64'd1);
        chk("tmo_wcnt", 64'(wcnt), 64'd0);

        // Start during DATA is ignored; word order intact
        pulse_start();
        wcnt = 0; x = 8'h00;
        send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
        exp_q.push_back({ADDR_W'(0), 32'hA1B2C3D4});
        send_byte(8'hD4, 1'b0); send_byte(8'hC3, 1'b1);
        send_byte(8'hB2, 1'b0); send_byte(8'hA1, 1'b0);
        x = 8'hD4 ^ 8'hC3 ^ 8'hB2 ^ 8'hA1;
        send_word(32'h0BADF00D, 1, x);
        send_byte(x, 1'b0);
        @(negedge clock);
        chk("ign_done", 64'(done), 64'd1);
        chk("ign_wcnt", 64'(wcnt), 64'd2);

        // Reset mid-download after word 0
        pulse_start();
        wcnt = 0; x = 8'h00;
        send_byte(8'h03, 1'b0); send_byte(8'h00, 1'b0);
        send_word(32'hCAFEF00D, 0, x);
        @(negedge clock);
        send_byte(8'h11, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_flags", 64'(flags()), 64'h0);
        byte_valid = 1'b1; byte_data = 8'h22;
        repeat (6) @(negedge clock);
        byte_valid = 1'b0;
        chk("rst_flags2", 64'(flags()), 64'h0);
        chk("rst_wcnt", 64'(wcnt), 64'd1);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_idle", 64'(flags()), 64'h0);

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
